multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Control FSM for the multicycle ARM-subset processor, replacing the single-cycle control unit.
- Sequences one shared memory, ALU and instruction register through FETCH/DECODE/EXECUTE/WRITEBACK steps.
- Holds the NZCV flag register and the per-instruction condition result.
- Inputs are instruction fields from the datapath; outputs are the datapath mux selects and write enables.

Parameters:
- none (ISA subset fixed: ADD, SUB, AND, ORR, LDR, STR, B).

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  synchronous, active-high.
- Cond  in  4  Instr[31:28].
- Op  in  2  Instr[27:26].
- Funct  in  6  Instr[25:20]: [5]=I, [4:1]=cmd, [0]=S or L.
- Rd  in  4  Instr[15:12].
- ALUFlags  in  4  {N,Z,C,V} from the ALU, current cycle.
- PCWrite  out  1  PC register enable.
- AdrSrc  out  1  memory address select: 0=PC, 1=ALUOut.
- MemWrite  out  1  data memory write.
- IRWrite  out  1  instruction register enable.
- ResultSrc  out  2  result select: 00=ALUOut, 01=Data, 10=ALUResult.
- ALUSrcA  out  1  ALU A select: 0=RD1, 1=PC.
- ALUSrcB  out  2  ALU B select: 00=RD2, 01=ExtImm, 10=constant 4.
- ALUControl  out  2  ALU operation: 00 ADD, 01 SUB, 10 AND, 11 ORR.
- ImmSrc  out  2  extender mode, equal to Op.
- RegSrc  out  2  [0]=(Op==10), [1]=(Op==01).
- RegWrite  out  1  register file write.
- Flags  out  4  registered {N,Z,C,V}.
- State  out  4  current state code, for debug.

Behaviour:
- State codes: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9. Codes 10-15 go to FETCH on the next edge; all their outputs are 0.
- Reset on the CLK edge with RESET=1: State=FETCH, Flags=0000, CondExR=0.
- While RESET=1, PCWrite, IRWrite, RegWrite and MemWrite are forced to 0.
- Transitions:
  - FETCH -> DECODE.
  - DECODE: Op=00 -> EXECI if Funct[5]=1, else EXECR; Op=01 -> MEMADR; Op=10 -> BRANCH; Op=11 -> FETCH (undefined instruction, no side effects).
  - MEMADR -> MEMRD if L=1, else MEMWR.
  - MEMRD -> MEMWB.
  - EXECR/EXECI -> ALUWB.
  - MEMWB, MEMWR, ALUWB, BRANCH -> FETCH.
- Cycles per instruction: B=3, STR=4, data-processing=4, LDR=5.
- Outputs are Moore functions of State, except ALUControl (EXEC states only) and the condition gating below. Unlisted outputs are 0.
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ALUControl=00, ResultSrc=10, PCWrite=1 (unconditional).
  - DECODE: ALUSrcA=1, ALUSrcB=10, ALUControl=00, ResultSrc=10.
  - MEMADR: ALUSrcA=0, ALUSrcB=01, ALUControl=00.
  - MEMRD: AdrSrc=1, ResultSrc=00.
  - MEMWB: ResultSrc=01, RegWrite=CondExR.
  - MEMWR: AdrSrc=1, MemWrite=CondExR.
  - EXECR: ALUSrcA=0, ALUSrcB=00, ALUControl from cmd.
  - EXECI: ALUSrcA=0, ALUSrcB=01, ALUControl from cmd.
  - ALUWB: ResultSrc=00, RegWrite=CondExR.
  - BRANCH: ALUSrcA=0, ALUSrcB=01, ALUControl=00, ResultSrc=10, PCWrite=CondExR.
- PC writeback: in MEMWB or ALUWB with Rd=1111, PCWrite=CondExR in addition to RegWrite.
- cmd decode (Funct[4:1]): 0100 ADD=00, 0010 SUB=01, 0000 AND=10, 1100 ORR=11. Any other cmd gives ALUControl=00 and no flag update.
- ImmSrc and RegSrc are combinational from Op in every state.
- CondEx is evaluated combinationally from Cond and the Flags register:
  - EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V.
  - HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V).
  - AL(1110)=1, 1111=0.
- CondExR is loaded with CondEx on the edge leaving DECODE and is used by all later states of that instruction. A flag update in EXEC therefore never changes the current instruction's condition.
- Flag update, on the edge leaving EXECR/EXECI, only when S=1 and CondExR=1:
  - N,Z always loaded from ALUFlags;
  - C,V loaded only for ADD/SUB; AND/ORR keep the old C,V.
- RESET asserted mid-instruction: abandon it, go to FETCH, no write enables that cycle.

Test Plan:
- Reset: RESET=1 for 2 cycles -> State=0, Flags=0000, all write enables 0. Release -> first FETCH has PCWrite=1, IRWrite=1.
- ADD R1,R2,R3 (Cond=1110, Op=00, Funct=001000) -> States 0,1,6,8. ALUWB has RegWrite=1, ResultSrc=00, ALUControl=00 in EXECR. Flags unchanged.
- SUBS with ALUFlags=0110 in EXECR -> Flags=0110 next cycle. A following BEQ (Cond=0000) -> States 0,1,9 with PCWrite=1 in BRANCH. A following BNE -> PCWrite=0 in BRANCH.
- LDR (Op=01, L=1) -> States 0,1,2,3,4; MEMRD AdrSrc=1; MEMWB ResultSrc=01, RegWrite=1. STREQ with Z=0 -> States 0,1,2,5 with MemWrite=0.
- ANDS with ALUFlags=1011 and prior Flags=0001 -> Flags=1001 (C,V kept). ADD with Rd=1111 -> ALUWB has both PCWrite=1 and RegWrite=1.
- Op=11 -> State 1 -> 0 with no enables. RESET pulsed during MEMRD -> State=0 next edge, RegWrite never asserted.

Source files
------------

// File: rtl/multicycle_control.sv
// Multicycle control FSM for the ARM-subset core: sequences fetch/decode/execute/writeback
// over a shared memory and ALU, and holds the NZCV flags plus the latched condition result.
module multicycle_control (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [3:0] Cond,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] ALUFlags,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic       RegWrite,
  output logic [3:0] Flags,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  state_t     state_reg;
  logic [3:0] flags_reg;   // {N,Z,C,V}
  logic       condexr_reg;
  logic       condex;
  logic [1:0] alu_op;
  logic       cmd_valid;
  logic       cmd_arith;

  // Condition evaluated against the registered flags, never the live ALU flags.
  always_comb begin
    condex = 1'b0;
    case (Cond)
      4'b0000: condex = flags_reg[2];
      4'b0001: condex = !flags_reg[2];
      4'b0010: condex = flags_reg[1];
      4'b0011: condex = !flags_reg[1];
      4'b0100: condex = flags_reg[3];
      4'b0101: condex = !flags_reg[3];
      4'b0110: condex = flags_reg[0];
      4'b0111: condex = !flags_reg[0];
      4'b1000: condex = flags_reg[1] && !flags_reg[2];
      4'b1001: condex = !flags_reg[1] || flags_reg[2];
      4'b1010: condex = (flags_reg[3] == flags_reg[0]);
      4'b1011: condex = (flags_reg[3] != flags_reg[0]);
      4'b1100: condex = !flags_reg[2] && (flags_reg[3] == flags_reg[0]);
      4'b1101: condex = flags_reg[2] || (flags_reg[3] != flags_reg[0]);
      4'b1110: condex = 1'b1;
      default: condex = 1'b0;
    endcase
  end

  always_comb begin
    alu_op    = 2'b00;
    cmd_valid = 1'b0;
    cmd_arith = 1'b0;
    case (Funct[4:1])
      4'b0100: begin alu_op = 2'b00; cmd_valid = 1'b1; cmd_arith = 1'b1; end
      4'b0010: begin alu_op = 2'b01; cmd_valid = 1'b1; cmd_arith = 1'b1; end
      4'b0000: begin alu_op = 2'b10; cmd_valid = 1'b1; end
      4'b1100: begin alu_op = 2'b11; cmd_valid = 1'b1; end
      default: begin alu_op = 2'b00; cmd_valid = 1'b0; end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg   <= S_FETCH;
      flags_reg   <= 4'b0000;
      condexr_reg <= 1'b0;
    end else begin
      case (state_reg)
        S_FETCH: state_reg <= S_DECODE;
        S_DECODE: begin
          condexr_reg <= condex;
          case (Op)
            2'b00:   state_reg <= Funct[5] ? S_EXECI : S_EXECR;
            2'b01:   state_reg <= S_MEMADR;
            2'b10:   state_reg <= S_BRANCH;
            default: state_reg <= S_FETCH;
          endcase
        end
        S_MEMADR: state_reg <= Funct[0] ? S_MEMRD : S_MEMWR;
        S_MEMRD:  state_reg <= S_MEMWB;
        S_EXECR, S_EXECI: begin
          state_reg <= S_ALUWB;
          if (Funct[0] && condexr_reg && cmd_valid) begin
            flags_reg[3:2] <= ALUFlags[3:2];
            if (cmd_arith)
              flags_reg[1:0] <= ALUFlags[1:0];
          end
        end
        default: state_reg <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUControl = 2'b00;
    RegWrite   = 1'b0;
    case (state_reg)
      S_FETCH: begin
        IRWrite = 1'b1; ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10; PCWrite = 1'b1;
      end
      S_DECODE: begin
        ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
      end
      S_MEMADR: ALUSrcB = 2'b01;
      S_MEMRD:  AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01; RegWrite = condexr_reg;
        PCWrite   = condexr_reg && (Rd == 4'b1111);
      end
      S_MEMWR: begin
        AdrSrc = 1'b1; MemWrite = condexr_reg;
      end
      S_EXECR: ALUControl = alu_op;
      S_EXECI: begin
        ALUSrcB = 2'b01; ALUControl = alu_op;
      end
      S_ALUWB: begin
        RegWrite = condexr_reg;
        PCWrite  = condexr_reg && (Rd == 4'b1111);
      end
      S_BRANCH: begin
        ALUSrcB = 2'b01; ResultSrc = 2'b10; PCWrite = condexr_reg;
      end
      default: ;
    endcase
    // Reset overrides every architectural write, even mid-instruction.
    if (RESET) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
    end
  end

  assign ImmSrc = Op;
  assign RegSrc = {(Op == 2'b01), (Op == 2'b10)};
  assign Flags  = flags_reg;
  assign State  = state_reg;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed testbench for multicycle_control: walks each instruction class through its
// state sequence and checks selects, enables and flag behaviour against hand-computed values.
module tb_multicycle_control;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [3:0] Cond = 4'd0;
  logic [1:0] Op = 2'd0;
  logic [5:0] Funct = 6'd0;
  logic [3:0] Rd = 4'd0;
  logic [3:0] ALUFlags = 4'd0;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, ALUSrcA, RegWrite;
  logic [1:0] ResultSrc, ALUSrcB, ALUControl, ImmSrc, RegSrc;
  logic [3:0] Flags, State;
  logic [3:0] en;

  int tests_run = 0;
  int tests_failed = 0;

  multicycle_control dut (
    .CLK(CLK), .RESET(RESET), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
    .ALUFlags(ALUFlags), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .ImmSrc(ImmSrc), .RegSrc(RegSrc), .RegWrite(RegWrite),
    .Flags(Flags), .State(State)
  );

  // {PCWrite, IRWrite, RegWrite, MemWrite}
  assign en = {PCWrite, IRWrite, RegWrite, MemWrite};

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic issue(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                       input logic [3:0] rd, input logic [3:0] af);
    Cond = c; Op = o; Funct = f; Rd = rd; ALUFlags = af;
    #1;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    step(); step();
    tests_run++;
    if ({State, Flags, en} !== {4'd0, 4'b0000, 4'b0000}) begin
      tests_failed++;
      $display("FAIL reset_state: got state=%0d flags=%b en=%b, want 0 0000 0000", State, Flags, en);
    end
    RESET = 1'b0;
    #1;
    tests_run++;
    if ({State, en} !== {4'd0, 4'b1100}) begin
      tests_failed++;
      $display("FAIL reset_first_fetch: got state=%0d en=%b, want 0 1100", State, en);
    end
    $display("[TB] reset done");
  endtask

  task automatic test_add();
    issue(4'hE, 2'b00, 6'b001000, 4'd1, 4'b1111);
    step();
    tests_run++;
    if ({State, en} !== {4'd1, 4'b0000}) begin
      tests_failed++;
      $display("FAIL add_decode: got state=%0d en=%b, want 1 0000", State, en);
    end
    step();
    tests_run++;
    if ({State, ALUSrcA, ALUSrcB, ALUControl} !== {4'd6, 1'b0, 2'b00, 2'b00}) begin
      tests_failed++;
      $display("FAIL add_execr: got state=%0d srca=%b srcb=%b aluctl=%b, want 6 0 00 00",
               State, ALUSrcA, ALUSrcB, ALUControl);
    end
    step();
    tests_run++;
    if ({State, en, ResultSrc, Flags} !== {4'd8, 4'b0010, 2'b00, 4'b0000}) begin
      tests_failed++;
      $display("FAIL add_aluwb: got state=%0d en=%b res=%b flags=%b, want 8 0010 00 0000",
               State, en, ResultSrc, Flags);
    end
    step();
    tests_run++;
    if (State !== 4'd0) begin
      tests_failed++;
      $display("FAIL add_return: got state=%0d, want 0", State);
    end
    $display("[TB] ADD R1,R2,R3 done");
  endtask

  task automatic test_subs_branch();
    issue(4'hE, 2'b00, 6'b000101, 4'd3, 4'b0110);
    step(); step();
    tests_run++;
    if ({State, ALUControl} !== {4'd6, 2'b01}) begin
      tests_failed++;
      $display("FAIL subs_execr: got state=%0d aluctl=%b, want 6 01", State, ALUControl);
    end
    step();
    tests_run++;
    if (Flags !== 4'b0110) begin
      tests_failed++;
      $display("FAIL subs_flags: got %b, want 0110", Flags);
    end
    step();
    $display("[TB] SUBS done");

    // SUBSNE with Z=1: condition fails, no write, no flag update
    issue(4'h1, 2'b00, 6'b000101, 4'd3, 4'b0000);
    step(); step(); step();
    tests_run++;
    if ({State, en, Flags} !== {4'd8, 4'b0000, 4'b0110}) begin
      tests_failed++;
      $display("FAIL subsne_skip: got state=%0d en=%b flags=%b, want 8 0000 0110", State, en, Flags);
    end
    step();
    $display("[TB] SUBSNE done");

    issue(4'h0, 2'b10, 6'b000000, 4'd0, 4'b0000);
    tests_run++;
    if ({ImmSrc, RegSrc} !== {2'b10, 2'b01}) begin
      tests_failed++;
      $display("FAIL branch_immsrc_regsrc: got %b %b, want 10 01", ImmSrc, RegSrc);
    end
    step(); step();
    tests_run++;
    if ({State, en, ALUSrcB, ResultSrc} !== {4'd9, 4'b1000, 2'b01, 2'b10}) begin
      tests_failed++;
      $display("FAIL beq_branch: got state=%0d en=%b srcb=%b res=%b, want 9 1000 01 10",
               State, en, ALUSrcB, ResultSrc);
    end
    step();
    tests_run++;
    if (State !== 4'd0) begin
      tests_failed++;
      $display("FAIL beq_return: got state=%0d, want 0", State);
    end
    $display("[TB] BEQ done");

    issue(4'h1, 2'b10, 6'b000000, 4'd0, 4'b0000);
    step(); step();
    tests_run++;
    if ({State, en} !== {4'd9, 4'b0000}) begin
      tests_failed++;
      $display("FAIL bne_branch: got state=%0d en=%b, want 9 0000", State, en);
    end
    step();
    $display("[TB] BNE done");
  endtask

  task automatic test_ldr_str();
    // ADDS to set Flags=0001 (Z clear)
    issue(4'hE, 2'b00, 6'b001001, 4'd4, 4'b0001);
    step(); step(); step();
    tests_run++;
    if (Flags !== 4'b0001) begin
      tests_failed++;
      $display("FAIL adds_flags: got %b, want 0001", Flags);
    end
    step();
    $display("[TB] ADDS done");

    issue(4'hE, 2'b01, 6'b011001, 4'd2, 4'b0000);
    tests_run++;
    if (RegSrc !== 2'b10) begin
      tests_failed++;
      $display("FAIL ldr_regsrc: got %b, want 10", RegSrc);
    end
    step(); step();
    tests_run++;
    if ({State, ALUSrcA, ALUSrcB} !== {4'd2, 1'b0, 2'b01}) begin
      tests_failed++;
      $display("FAIL ldr_memadr: got state=%0d srca=%b srcb=%b, want 2 0 01", State, ALUSrcA, ALUSrcB);
    end
    step();
    tests_run++;
    if ({State, AdrSrc, ResultSrc, en} !== {4'd3, 1'b1, 2'b00, 4'b0000}) begin
      tests_failed++;
      $display("FAIL ldr_memrd: got state=%0d adr=%b res=%b en=%b, want 3 1 00 0000",
               State, AdrSrc, ResultSrc, en);
    end
    step();
    tests_run++;
    if ({State, ResultSrc, en} !== {4'd4, 2'b01, 4'b0010}) begin
      tests_failed++;
      $display("FAIL ldr_memwb: got state=%0d res=%b en=%b, want 4 01 0010", State, ResultSrc, en);
    end
    step();
    tests_run++;
    if (State !== 4'd0) begin
      tests_failed++;
      $display("FAIL ldr_return: got state=%0d, want 0", State);
    end
    $display("[TB] LDR done");

    issue(4'h0, 2'b01, 6'b011000, 4'd2, 4'b0000);
    step(); step(); step();
    tests_run++;
    if ({State, AdrSrc, en} !== {4'd5, 1'b1, 4'b0000}) begin
      tests_failed++;
      $display("FAIL streq_memwr: got state=%0d adr=%b en=%b, want 5 1 0000", State, AdrSrc, en);
    end
    step();
    $display("[TB] STREQ done");

    issue(4'hE, 2'b01, 6'b011000, 4'd2, 4'b0000);
    step(); step(); step();
    tests_run++;
    if ({State, en} !== {4'd5, 4'b0001}) begin
      tests_failed++;
      $display("FAIL str_memwr: got state=%0d en=%b, want 5 0001", State, en);
    end
    step();
    $display("[TB] STR done");
  endtask

  task automatic test_ands_pcwb();
    issue(4'hE, 2'b00, 6'b100001, 4'd5, 4'b1011);
    step(); step();
    tests_run++;
    if ({State, ALUSrcB, ALUControl} !== {4'd7, 2'b01, 2'b10}) begin
      tests_failed++;
      $display("FAIL ands_execi: got state=%0d srcb=%b aluctl=%b, want 7 01 10", State, ALUSrcB, ALUControl);
    end
    step();
    tests_run++;
    if (Flags !== 4'b1001) begin
      tests_failed++;
      $display("FAIL ands_flags: got %b, want 1001", Flags);
    end
    step();
    $display("[TB] ANDS done");

    // Unsupported cmd (EOR) with S=1: ALUControl=00, flags untouched
    issue(4'hE, 2'b00, 6'b000011, 4'd5, 4'b0110);
    step(); step();
    tests_run++;
    if ({State, ALUControl} !== {4'd6, 2'b00}) begin
      tests_failed++;
      $display("FAIL eors_execr: got state=%0d aluctl=%b, want 6 00", State, ALUControl);
    end
    step();
    tests_run++;
    if (Flags !== 4'b1001) begin
      tests_failed++;
      $display("FAIL eors_flags: got %b, want 1001", Flags);
    end
    step();
    $display("[TB] EORS done");

    issue(4'hE, 2'b00, 6'b001000, 4'd15, 4'b0000);
    step(); step(); step();
    tests_run++;
    if ({State, en} !== {4'd8, 4'b1010}) begin
      tests_failed++;
      $display("FAIL add_pc_aluwb: got state=%0d en=%b, want 8 1010", State, en);
    end
    step();
    $display("[TB] ADD PC done");
  endtask

  task automatic test_undef_reset();
    issue(4'hE, 2'b11, 6'b000000, 4'd0, 4'b0000);
    step();
    tests_run++;
    if ({State, en} !== {4'd1, 4'b0000}) begin
      tests_failed++;
      $display("FAIL undef_decode: got state=%0d en=%b, want 1 0000", State, en);
    end
    step();
    tests_run++;
    if ({State, en} !== {4'd0, 4'b1100}) begin
      tests_failed++;
      $display("FAIL undef_return: got state=%0d en=%b, want 0 1100", State, en);
    end
    $display("[TB] undefined op done");

    issue(4'hE, 2'b01, 6'b011001, 4'd2, 4'b0000);
    step(); step(); step();
    tests_run++;
    if (State !== 4'd3) begin
      tests_failed++;
      $display("FAIL rst_mid_memrd: got state=%0d, want 3", State);
    end
    RESET = 1'b1;
    #1;
    tests_run++;
    if (en !== 4'b0000) begin
      tests_failed++;
      $display("FAIL rst_mid_gate: got en=%b, want 0000", en);
    end
    step();
    tests_run++;
    if ({State, en, Flags} !== {4'd0, 4'b0000, 4'b0000}) begin
      tests_failed++;
      $display("FAIL rst_mid_fetch: got state=%0d en=%b flags=%b, want 0 0000 0000", State, en, Flags);
    end
    RESET = 1'b0;
    #1;
    tests_run++;
    if ({State, en} !== {4'd0, 4'b1100}) begin
      tests_failed++;
      $display("FAIL rst_mid_release: got state=%0d en=%b, want 0 1100", State, en);
    end
    $display("[TB] reset during MEMRD done");
  endtask

  initial begin
    test_reset();
    test_add();
    test_subs_branch();
    test_ldr_str();
    test_ands_pcwb();
    test_undef_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
